// File: rtl/pipe_hazard_sched.sv
// pipe_hazard_sched: hazard controller for a 5-stage (F/D/E/M/W) MIPS pipeline.
// Tracks a shadow copy of the E/M/W destination state and produces forwarding
// selects, load-use stalls, branch flushes and decode-stage write/read bypass.
// Optional build feature: define HAZ_PERF_EN to add saturating stall_cnt and
// flush_cnt performance counters.
//
// Handshake note: there is no valid/ready interface here. The pipeline
// registers obey stall/flush every cycle. Flush outranks stall. A stalled D
// instruction is presented again by the datapath until stallD drops.
module pipe_hazard_sched #(
  parameter int REGW = 5,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [REGW-1:0] rsD,
  input  logic [REGW-1:0] rtD,
  input  logic            useRsD,
  input  logic            useRtD,
  input  logic            regwriteD,
  input  logic            mem2regD,
  input  logic [REGW-1:0] writeregD,
  input  logic            pcsrcM,
  output logic            stallF,
  output logic            stallD,
  output logic            flushD,
  output logic            flushE,
  output logic            flushM,
  output logic [1:0]      forwardAE,
  output logic [1:0]      forwardBE,
  output logic            bypassAD,
  output logic            bypassBD
`ifdef HAZ_PERF_EN
  ,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt
`endif
);

  // Shadow scoreboard of the instructions in D, E, M and W.
  logic            valid_d;
  logic            v_e, rw_e, m2r_e, use_rs_e, use_rt_e;
  logic [REGW-1:0] dst_e, rs_e, rt_e;
  logic            v_m, rw_m;
  logic [REGW-1:0] dst_m;
  logic            v_w, rw_w;
  logic [REGW-1:0] dst_w;

  logic            lw_stall;
  logic            m_writes, w_writes;

  // Load-use detection and producer qualifiers. Register $0 never matches.
  always_comb begin
    lw_stall = valid_d & v_e & rw_e & m2r_e & (dst_e != '0) &
               ((useRsD & (rsD == dst_e)) | (useRtD & (rtD == dst_e)));
    m_writes = v_m & rw_m & (dst_m != '0);
    w_writes = v_w & rw_w & (dst_w != '0);
  end

  // Stall/flush, forwarding and D bypass. All outputs are held at 0 during reset.
  always_comb begin
    stallF    = 1'b0;
    stallD    = 1'b0;
    flushD    = 1'b0;
    flushE    = 1'b0;
    flushM    = 1'b0;
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    bypassAD  = 1'b0;
    bypassBD  = 1'b0;
    if (reset) begin
      if (pcsrcM) begin
        flushD = 1'b1;
        flushE = 1'b1;
        flushM = 1'b1;
      end else if (lw_stall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
      if (m_writes && use_rs_e && (dst_m == rs_e))      forwardAE = 2'b10;
      else if (w_writes && use_rs_e && (dst_w == rs_e)) forwardAE = 2'b01;
      if (m_writes && use_rt_e && (dst_m == rt_e))      forwardBE = 2'b10;
      else if (w_writes && use_rt_e && (dst_w == rt_e)) forwardBE = 2'b01;
      bypassAD = valid_d & useRsD & w_writes & (dst_w == rsD);
      bypassBD = valid_d & useRtD & w_writes & (dst_w == rtD);
    end
  end

  // Advance the shadow pipeline; flush and stall insert bubbles (v=0, fields 0).
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_d  <= 1'b0;
      v_e      <= 1'b0;
      rw_e     <= 1'b0;
      m2r_e    <= 1'b0;
      use_rs_e <= 1'b0;
      use_rt_e <= 1'b0;
      dst_e    <= '0;
      rs_e     <= '0;
      rt_e     <= '0;
      v_m      <= 1'b0;
      rw_m     <= 1'b0;
      dst_m    <= '0;
      v_w      <= 1'b0;
      rw_w     <= 1'b0;
      dst_w    <= '0;
    end else begin
      v_w   <= v_m;
      rw_w  <= rw_m;
      dst_w <= dst_m;
      if (pcsrcM) begin
        v_m   <= 1'b0;
        rw_m  <= 1'b0;
        dst_m <= '0;
      end else begin
        v_m   <= v_e;
        rw_m  <= rw_e;
        dst_m <= dst_e;
      end
      if (pcsrcM || lw_stall || !valid_d) begin
        v_e      <= 1'b0;
        rw_e     <= 1'b0;
        m2r_e    <= 1'b0;
        use_rs_e <= 1'b0;
        use_rt_e <= 1'b0;
        dst_e    <= '0;
        rs_e     <= '0;
        rt_e     <= '0;
      end else begin
        v_e      <= 1'b1;
        rw_e     <= regwriteD;
        m2r_e    <= mem2regD;
        use_rs_e <= useRsD;
        use_rt_e <= useRtD;
        dst_e    <= writeregD;
        rs_e     <= rsD;
        rt_e     <= rtD;
      end
      if (pcsrcM)        valid_d <= 1'b0;
      else if (!lw_stall) valid_d <= 1'b1;
    end
  end

`ifdef HAZ_PERF_EN
  // Saturating counters of load-use stall cycles and taken-branch flush cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (lw_stall && !pcsrcM && (stall_cnt != '1))
        stall_cnt <= stall_cnt + {{(CNTW-1){1'b0}}, 1'b1};
      if (pcsrcM && (flush_cnt != '1))
        flush_cnt <= flush_cnt + {{(CNTW-1){1'b0}}, 1'b1};
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_sched.sv
// tb_pipe_hazard_sched: scoreboard bench for pipe_hazard_sched. Each cycle's
// expected output vector is queued before the cycle is driven and popped at
// the following negedge. Vector layout:
// {stallF,stallD,flushD,flushE,flushM,forwardAE,forwardBE,bypassAD,bypassBD}
module tb_pipe_hazard_sched;

  localparam logic [10:0] E_NONE  = 11'b00000000000;
  localparam logic [10:0] E_STALL = 11'b11010000000;
  localparam logic [10:0] E_FLUSH = 11'b00111000000;
  localparam logic [10:0] E_FA_M  = 11'b00000100000;
  localparam logic [10:0] E_FA_W  = 11'b00000010000;
  localparam logic [10:0] E_FB_W  = 11'b00000000100;
  localparam logic [10:0] E_BYP_A = 11'b00000000010;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] rsD = '0, rtD = '0, writeregD = '0;
  logic       useRsD = 1'b0, useRtD = 1'b0, regwriteD = 1'b0, mem2regD = 1'b0, pcsrcM = 1'b0;
  logic       stallF, stallD, flushD, flushE, flushM, bypassAD, bypassBD;
  logic [1:0] forwardAE, forwardBE;
`ifdef HAZ_PERF_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  logic        rst_val = 1'b0;
  logic [10:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  pipe_hazard_sched dut (
    .clk(clk), .reset(reset), .rsD(rsD), .rtD(rtD), .useRsD(useRsD), .useRtD(useRtD),
    .regwriteD(regwriteD), .mem2regD(mem2regD), .writeregD(writeregD), .pcsrcM(pcsrcM),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE), .flushM(flushM),
    .forwardAE(forwardAE), .forwardBE(forwardBE), .bypassAD(bypassAD), .bypassBD(bypassBD)
`ifdef HAZ_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  // Driver + scoreboard check: drive one D-stage instruction for one cycle,
  // then compare the outputs at the negedge with the head of the queue.
  task automatic cyc(input string name, input logic [4:0] rs, input logic [4:0] rt,
                     input logic urs, input logic urt, input logic rw, input logic m2r,
                     input logic [4:0] wr, input logic pc);
    logic [10:0] got, exp;
    @(posedge clk);
    #1;
    reset = rst_val; rsD = rs; rtD = rt; useRsD = urs; useRtD = urt;
    regwriteD = rw; mem2regD = m2r; writeregD = wr; pcsrcM = pc;
    @(negedge clk);
    got = {stallF, stallD, flushD, flushE, flushM, forwardAE, forwardBE, bypassAD, bypassBD};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty, got %b", name, got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL %s got %b expected %b", name, got, exp);
      end
    end
  endtask

  task automatic nop(input string name);
    exp_q.push_back(E_NONE);
    cyc(name, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic test_reset();
    rst_val = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(E_NONE);
      cyc("reset_hold", 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end
    rst_val = 1'b1;
    exp_q.push_back(E_NONE);
    cyc("reset_release", 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9, 1'b0);
    for (int i = 0; i < 3; i++) nop("reset_settle");
  endtask

  task automatic test_fwd_m();
    exp_q.push_back(E_NONE);
    cyc("fwdm_add", 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0);
    exp_q.push_back(E_NONE);
    cyc("fwdm_sub", 5'd3, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4, 1'b0);
    exp_q.push_back(E_FA_M);
    cyc("fwdm_fwd", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) nop("fwdm_drain");
  endtask

  task automatic test_fwd_w();
    exp_q.push_back(E_NONE);
    cyc("fwdw_add", 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0);
    nop("fwdw_gap");
    exp_q.push_back(E_NONE);
    cyc("fwdw_sub", 5'd3, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4, 1'b0);
    exp_q.push_back(E_FA_W);
    cyc("fwdw_fwd", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) nop("fwdw_drain");
  endtask

  task automatic test_bypass();
    exp_q.push_back(E_NONE);
    cyc("byp_add7", 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd7, 1'b0);
    nop("byp_gap1");
    nop("byp_gap2");
    exp_q.push_back(E_BYP_A);
    cyc("byp_hit", 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    exp_q.push_back(E_NONE);
    cyc("byp_once", 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) nop("byp_drain");
  endtask

  task automatic test_load_use();
    exp_q.push_back(E_NONE);
    cyc("lu_lw", 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0);
    exp_q.push_back(E_STALL);
    cyc("lu_stall", 5'd5, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd6, 1'b0);
    exp_q.push_back(E_NONE);
    cyc("lu_once", 5'd5, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd6, 1'b0);
    exp_q.push_back(E_FB_W);
    cyc("lu_fwdw", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) nop("lu_drain");
  endtask

  task automatic test_load_r0();
    exp_q.push_back(E_NONE);
    cyc("r0_lw", 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0);
    exp_q.push_back(E_NONE);
    cyc("r0_use", 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8, 1'b0);
    for (int i = 0; i < 4; i++) nop("r0_drain");
  endtask

  task automatic test_branch_lwstall();
    exp_q.push_back(E_NONE);
    cyc("br_lw", 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0);
    exp_q.push_back(E_FLUSH);
    cyc("br_flush", 5'd0, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
    exp_q.push_back(E_NONE);
    cyc("br_after1", 5'd0, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    exp_q.push_back(E_NONE);
    cyc("br_after2", 5'd0, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) nop("br_drain");
  endtask

`ifdef HAZ_PERF_EN
  task automatic test_perf();
    rst_val = 1'b0;
    nop("perf_reset");
    checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      errors++;
      $display("FAIL perf_clear got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
    end
    rst_val = 1'b1;
    nop("perf_release");
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(E_NONE);
      cyc("perf_lw", 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0);
      exp_q.push_back(E_STALL);
      cyc("perf_stall", 5'd0, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
      exp_q.push_back(E_NONE);
      cyc("perf_hold", 5'd0, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
      exp_q.push_back(E_FB_W);
      cyc("perf_fwd", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(E_FLUSH);
      cyc("perf_branch", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
      nop("perf_after_br");
    end
    checks++;
    if (stall_cnt !== 16'd3) begin
      errors++;
      $display("FAIL perf_stall_cnt got %0d expected 3", stall_cnt);
    end
    checks++;
    if (flush_cnt !== 16'd2) begin
      errors++;
      $display("FAIL perf_flush_cnt got %0d expected 2", flush_cnt);
    end
  endtask
`endif

  // Test sequence and final report.
  initial begin
    test_reset();
    test_fwd_m();
    test_fwd_w();
    test_bypass();
    test_load_use();
    test_load_r0();
    test_branch_lwstall();
`ifdef HAZ_PERF_EN
    test_perf();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations got %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_sched.md
Name: pipe_hazard_sched

Overview:
- Hazard controller for the 5-stage pipelined MIPS core (F/D/E/M/W).
- Keeps its own shadow scoreboard of the destination, regwrite and mem2reg state of the instructions in E, M and W.
- From that state it drives ALU-operand forwarding selects, load-use stalls and branch flushes.
- The datapath pipeline registers gain stall and flush inputs; this block is their only driver.

Parameters:
- REGW, 5, register-specifier width.
- CNTW, 16, width of the optional performance counters.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- rsD  in  REGW  instrD[25:21].
- rtD  in  REGW  instrD[20:16].
- useRsD  in  1  instruction in D reads rs.
- useRtD  in  1  instruction in D reads rt.
- regwriteD  in  1  control unit output for D.
- mem2regD  in  1  D instruction is a load.
- writeregD  in  REGW  destination resolved in D (RegDst mux applied).
- pcsrcM  in  1  taken branch resolved in M (branchM & zeroM).
- stallF  out  1  hold PC.
- stallD  out  1  hold F/D register.
- flushD  out  1  clear F/D register to bubble.
- flushE  out  1  clear D/E register to bubble.
- flushM  out  1  clear E/M register to bubble.
- forwardAE  out  2  SrcA select: 00 Rd1E, 10 ALUoutM, 01 resultW.
- forwardBE  out  2  same encoding, for Rd2E/writedata.
- bypassAD  out  1  D rs read must take resultW (same-cycle write/read).
- bypassBD  out  1  same, for rt.

Behaviour:
- Internal state, all cleared on reset:
  - validD.
  - E slot: vE, rwE, m2rE, dstE, rsE, rtE, useRsE, useRtE.
  - M slot: vM, rwM, dstM.
  - W slot: vW, rwW, dstW.
- Reset: while reset==0 every output is 0. On the first edge with reset low, all state clears. The first cycle after reset is released has validD=0.
- Matching rule: a register matches only if it is nonzero; $0 never matches.
- Load-use stall (lwstall), combinational:
  - lwstall = validD & vE & rwE & m2rE & dstE!=0 & ((useRsD & rsD==dstE) | (useRtD & rtD==dstE)).
  - Effect: stallF = stallD = flushE = lwstall.
- Branch flush, combinational: when pcsrcM=1, flushD = flushE = flushM = 1 and stallF = stallD = 0. pcsrcM overrides lwstall.
- Forwarding, combinational from state:
  - forwardAE = 10 if vM & rwM & dstM!=0 & useRsE & dstM==rsE.
  - Else forwardAE = 01 if vW & rwW & dstW!=0 & useRsE & dstW==rsE.
  - Else forwardAE = 00.
  - M has priority over W. forwardBE is identical using rtE/useRtE.
- D bypass: bypassAD = validD & useRsD & vW & rwW & dstW!=0 & dstW==rsD. bypassBD is the same for rt.
- Shadow update each edge (reset=1):
  - W <= M.
  - M <= pcsrcM ? bubble : E.
  - E <= (pcsrcM | lwstall | !validD) ? bubble : D fields.
  - validD <= pcsrcM ? 0 : (lwstall ? validD : 1).
  - A bubble has v=0 and all other fields 0.
- Latency: a load followed immediately by a dependent instruction costs exactly 1 stall cycle, then forwardXE=01 from W. A taken branch costs 3 flushed slots.
- Simultaneous pcsrcM and lwstall: flush wins. No stall. The D instruction is discarded.
- Reset mid-operation: pending stall/flush is dropped and the scoreboard is emptied on the next edge.

Optional Feature:
- Macro: HAZ_PERF_EN.
- When defined, adds outputs stall_cnt and flush_cnt, each CNTW bits.
  - stall_cnt increments on cycles with lwstall & !pcsrcM.
  - flush_cnt increments on cycles with pcsrcM.
  - Both saturate at all-ones and clear on reset.
- When not defined, these ports and counters are absent. Core behaviour is identical in both builds.

Test Plan:
- Reset low 3 cycles with random inputs -> all outputs 0. First cycle after release, regwriteD=1, useRsD=1, rsD=5 -> no stall.
- add $3 in D, next cycle sub $4,$3,$1 in D -> one cycle later forwardAE=10. If instead separated by one nop -> forwardAE=01.
- lw $2 in E, D reads rt=$2 (useRtD=1) -> stallF=stallD=flushE=1 for exactly 1 cycle, then forwardBE=01 next cycle.
- lw $0 in E, D reads $0 -> no stall; forwardAE=forwardBE=00 throughout.
- pcsrcM=1 in the same cycle as a load-use condition -> flushD=flushE=flushM=1, stallF=0. Next 2 cycles show no forwarding from flushed slots.
- W writes $7 while D reads rs=$7 -> bypassAD=1 that cycle only. With HAZ_PERF_EN, 3 load-use stalls and 2 taken branches -> stall_cnt=3, flush_cnt=2.
